data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 189 ++++++++++++++++++
 tb/tb_data_cache.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// 16 lines x 4 words of 16 bits. A one-entry write buffer decouples CPU
// writes from memory, and a three-state controller (IDLE/DRAIN/FILL) owns
// the memory port. Pending writes always drain before any line fill.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module data_cache (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        IO_WC,
    input  logic        IO_RC,
    input  logic        IO_n_LB_w,
    output logic [15:0] data_in,
    output logic        d_cache_miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_n_LB,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL
    } state_t;

    state_t state, state_nxt;

    // Cache storage
    logic [15:0] data_mem [0:15][0:3];
    logic [9:0]  tag_mem  [0:15];
    logic [15:0] valid;

    // Fill beat counter (word within the line being fetched)
    logic [1:0]  beat;

    // One-entry write buffer
    logic        wb_valid;
    logic [15:0] wb_addr;
    logic [15:0] wb_data;
    logic        wb_lane;

    // Address decode
    logic [1:0]  offset;
    logic [3:0]  index;
    logic [9:0]  tag;
    logic        hit;
    logic        wr_take;
    logic        fill_start;
    logic        fill_beat;
    logic        fill_last;
    logic        drain_done;

    assign offset = address[1:0];
    assign index  = address[5:2];
    assign tag    = address[15:6];
    assign hit    = valid[index] && (tag_mem[index] == tag);

    // Read data is always the array word at the CPU address; the CPU only
    // trusts it on a cycle where d_cache_miss is low.
    assign data_in = data_mem[index][offset];

    assign d_cache_miss = (IO_RC & ~hit) | (IO_WC & wb_valid) | (state != IDLE);

    // A write is taken only on an unstalled edge outside reset.
    assign wr_take    = IO_WC & ~d_cache_miss & ~RST;
    assign fill_beat  = (state == FILL) && mem_ack;
    assign fill_last  = fill_beat && (beat == 2'd3);
    assign drain_done = (state == DRAIN) && mem_ack;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and memory-port drive
    // NOTE: every output of this block gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wb_addr;
        mem_wdata  = wb_data;
        mem_n_LB   = wb_lane;
        fill_start = 1'b0;
        case (state)
            IDLE: begin
                // A buffered write must reach memory before any refill.
                if (wb_valid) begin
                    state_nxt = DRAIN;
                end else if (IO_RC && !hit) begin
                    state_nxt  = FILL;
                    fill_start = 1'b1;
                end
            end
            DRAIN: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_nxt = IDLE;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag, index, beat};
                if (mem_ack && (beat == 2'd3)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fill beat counter; wraps back to 0 after the 4th beat
    always_ff @(posedge clk) begin
        if (RST)            beat <= 2'd0;
        else if (fill_beat) beat <= beat + 2'd1;
    end

    // Write buffer: loaded by a taken CPU write, emptied by the drain ack
    always_ff @(posedge clk) begin
        if (RST) begin
            wb_valid <= 1'b0;
        end else if (wr_take) begin
            wb_valid <= 1'b1;
            wb_addr  <= address;
            wb_data  <= data_out;
            wb_lane  <= IO_n_LB_w;
        end else if (drain_done) begin
            wb_valid <= 1'b0;
        end
    end

    // Valid bits and tags. The line is invalidated when its refill starts so
    // a half-overwritten line can never hit under its old tag; it becomes
    // valid again only with the last beat.
    always_ff @(posedge clk) begin
        if (RST) begin
            valid <= '0;
        end else if (fill_start) begin
            valid[index] <= 1'b0;
        end else if (fill_last) begin
            valid[index]   <= 1'b1;
            tag_mem[index] <= tag;
        end
    end

    // Data array: refill beats and byte writes on a write hit
    // NOTE: the data array is intentionally not reset; the valid bits alone
    // decide whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (!RST) begin
            if (fill_beat) begin
                data_mem[index][beat] <= mem_rdata;
            end else if (wr_take && hit) begin
                if (IO_n_LB_w) data_mem[index][offset][7:0]  <= data_out[7:0];
                else           data_mem[index][offset][15:8] <= data_out[15:8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic rd_take;

    // A read is only ever taken when it hits.
    assign rd_take = IO_RC & ~d_cache_miss;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (RST) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (rd_take && (hit_count != 16'hFFFF))     hit_count  <= hit_count + 16'd1;
            if (fill_start && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. A behavioural memory
// responder services the memory port; the expected CPU view is a flat
// shadow memory (the cache must be transparent), and line residency is
// tracked per index to predict fills.
module tb_data_cache;

    logic        clk;
    logic        RST;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        IO_WC;
    logic        IO_RC;
    logic        IO_n_LB_w;
    logic [15:0] data_in;
    logic        d_cache_miss;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_n_LB;
    logic        mem_ack;
    logic [15:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    data_cache dut (
        .clk          (clk),
        .RST          (RST),
        .address      (address),
        .data_out     (data_out),
        .IO_WC        (IO_WC),
        .IO_RC        (IO_RC),
        .IO_n_LB_w    (IO_n_LB_w),
        .data_in      (data_in),
        .d_cache_miss (d_cache_miss),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_n_LB     (mem_n_LB),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        lane;
    } wr_t;

    // Memory model (responder-owned) and expected CPU view (test-owned)
    logic [15:0] mem    [0:65535];
    logic [15:0] shadow [0:65535];
    bit          mem_init_done = 1'b0;
    logic [15:0] rd_log [$];
    wr_t         wr_log [$];
    int          fills_seen = 0;

    // Responder controls
    int base_delay = 0;
    bit rand_delay = 1'b0;
    int wait_cnt   = 0;
    int rnd_delay  = 0;

    // Line residency model and expected counts
    bit         line_valid [0:15];
    logic [9:0] line_tag   [0:15];
    int         exp_fills;
    int         exp_hits;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] init_word(int a);
        logic [15:0] w;
        w = 16'(a) ^ 16'h3C5A;
        if (a >= 'h40 && a <= 'h43) w = 16'hA000 + 16'(a - 'h40);
        return w;
    endfunction

    // Memory responder: decides mem_ack for the coming edge on each falling
    // edge. The ack arrives after a programmable number of request cycles.
    always @(negedge clk) begin : responder
        int thr;
        if (!mem_init_done) begin
            for (int a = 0; a < 65536; a++) mem[a] = init_word(a);
            mem_init_done = 1'b1;
        end
        thr = rand_delay ? rnd_delay : base_delay;
        if (mem_req) begin
            if (wait_cnt >= thr) begin
                mem_ack   = 1'b1;
                wait_cnt  = 0;
                rnd_delay = $urandom_range(0, 2);
                if (mem_we) begin
                    wr_log.push_back('{mem_addr, mem_wdata, mem_n_LB});
                    if (mem_n_LB) mem[mem_addr][7:0]  = mem_wdata[7:0];
                    else          mem[mem_addr][15:8] = mem_wdata[15:8];
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = mem[mem_addr];
                    rd_log.push_back(mem_addr);
                    if (mem_addr[1:0] == 2'd0) fills_seen++;
                end
            end else begin
                mem_ack   = 1'b0;
                wait_cnt++;
                mem_rdata = 16'($urandom);
            end
        end else begin
            // Spurious acks while idle must be ignored by the cache.
            mem_ack   = rand_delay ? 1'($urandom_range(0, 1)) : 1'b0;
            wait_cnt  = 0;
            mem_rdata = 16'($urandom);
        end
    end

    // Present one CPU request at posedge+1 and hold it until taken. Returns
    // the stall cycles, data_in on the taking cycle, and the expected word.
    task automatic cpu_op(input bit rc, input bit wc, input logic [15:0] addr,
                          input logic [15:0] data, input bit lane,
                          output int stall, output logic [15:0] got,
                          output logic [15:0] exp);
        logic [3:0] idx;
        logic [9:0] tg;
        bit         pred_miss;
        idx       = addr[5:2];
        tg        = addr[15:6];
        pred_miss = rc && !(line_valid[idx] && line_tag[idx] == tg);
        address   = addr;
        data_out  = data;
        IO_RC     = rc;
        IO_WC     = wc;
        IO_n_LB_w = lane;
        stall     = 0;
        @(negedge clk);
        while (d_cache_miss && stall < 500) begin
            stall++;
            @(negedge clk);
        end
        got = data_in;
        exp = shadow[addr];
        if (stall < 500) begin
            if (rc) begin
                exp_hits++;
                if (pred_miss) begin
                    exp_fills++;
                    line_valid[idx] = 1'b1;
                    line_tag[idx]   = tg;
                end
            end
            if (wc) begin
                if (lane) shadow[addr][7:0]  = data[7:0];
                else      shadow[addr][15:8] = data[15:8];
            end
        end
        @(posedge clk);
        #1;
        IO_RC = 1'b0;
        IO_WC = 1'b0;
    endtask

    // Wait until the memory port has been quiet for three cycles.
    task automatic wait_quiet(output bit ok);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_req) quiet = 0;
            else         quiet++;
        end
        ok = (quiet >= 3);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        IO_RC   = 1'b1;
        address = 16'h0041;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b expected 0", mem_req); end
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
        n_checks++;
        if (d_cache_miss !== 1'b1) begin n_fail++; $display("FAIL reset_read_misses got %b expected 1", d_cache_miss); end
        IO_RC = 1'b0;
        #1;
        n_checks++;
        if (d_cache_miss !== 1'b0) begin n_fail++; $display("FAIL reset_idle_no_stall got %b expected 0", d_cache_miss); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_stats got %h/%h expected 0/0", hit_count, miss_count);
        end
`endif
        for (int i = 0; i < 16; i++) line_valid[i] = 1'b0;
        exp_fills = 0;
        exp_hits  = 0;
        @(posedge clk);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_read_miss();
        int          s;
        int          base;
        logic [15:0] got, exp;
        base = rd_log.size();
        cpu_op(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, s, got, exp);
        n_checks++;
        if (s !== 5) begin n_fail++; $display("FAIL miss_latency got %0d expected 5", s); end
        n_checks++;
        if (rd_log.size() !== base + 4) begin n_fail++; $display("FAIL fill_beats got %0d expected 4", rd_log.size() - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_log[base + i] !== 16'h0040 + 16'(i)) begin
                n_fail++; $display("FAIL fill_addr%0d got %h expected %h", i, rd_log[base + i], 16'h0040 + 16'(i));
            end
        end
        n_checks++;
        if (got !== 16'hA001) begin n_fail++; $display("FAIL read_after_fill got %h expected a001", got); end
    endtask

    task automatic test_write_through();
        int          s;
        int          base;
        bit          ok;
        logic [15:0] got, exp;
        base = wr_log.size();
        cpu_op(1'b0, 1'b1, 16'h0041, 16'h55AA, 1'b0, s, got, exp);
        n_checks++;
        if (s !== 0) begin n_fail++; $display("FAIL write_hit_stall got %0d expected 0", s); end
        cpu_op(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, s, got, exp);
        n_checks++;
        if (s !== 0) begin n_fail++; $display("FAIL reread_stall got %0d expected 0", s); end
        n_checks++;
        if (got !== 16'h5501) begin n_fail++; $display("FAIL byte_merge got %h expected 5501", got); end
        wait_quiet(ok);
        n_checks++;
        if (!ok || wr_log.size() !== base + 1) begin
            n_fail++; $display("FAIL drain_count got %0d expected 1", wr_log.size() - base);
        end else begin
            n_checks++;
            if (wr_log[base].addr !== 16'h0041 || wr_log[base].data !== 16'h55AA || wr_log[base].lane !== 1'b0) begin
                n_fail++; $display("FAIL drain_beat got %h/%h/%b expected 0041/55aa/0",
                                   wr_log[base].addr, wr_log[base].data, wr_log[base].lane);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          s1, s2;
        int          base;
        bit          ok;
        logic [15:0] got, exp;
        base_delay = 3;
        base = wr_log.size();
        cpu_op(1'b0, 1'b1, 16'h0100, 16'h1234, 1'b1, s1, got, exp);
        cpu_op(1'b0, 1'b1, 16'h0104, 16'hBEEF, 1'b0, s2, got, exp);
        n_checks++;
        if (s1 !== 0) begin n_fail++; $display("FAIL b2b_first_stall got %0d expected 0", s1); end
        n_checks++;
        if (s2 !== 5) begin n_fail++; $display("FAIL b2b_second_stall got %0d expected 5", s2); end
        wait_quiet(ok);
        n_checks++;
        if (!ok || wr_log.size() !== base + 2) begin
            n_fail++; $display("FAIL b2b_count got %0d expected 2", wr_log.size() - base);
        end else begin
            n_checks++;
            if (wr_log[base].addr !== 16'h0100 || wr_log[base].data !== 16'h1234 || wr_log[base].lane !== 1'b1) begin
                n_fail++; $display("FAIL b2b_first got %h/%h/%b expected 0100/1234/1",
                                   wr_log[base].addr, wr_log[base].data, wr_log[base].lane);
            end
            n_checks++;
            if (wr_log[base + 1].addr !== 16'h0104 || wr_log[base + 1].data !== 16'hBEEF || wr_log[base + 1].lane !== 1'b0) begin
                n_fail++; $display("FAIL b2b_second got %h/%h/%b expected 0104/beef/0",
                                   wr_log[base + 1].addr, wr_log[base + 1].data, wr_log[base + 1].lane);
            end
        end
        base_delay = 0;
    endtask

    task automatic test_evict();
        int          s;
        int          base;
        logic [15:0] got, exp;
        base = rd_log.size();
        cpu_op(1'b1, 1'b0, 16'h0441, 16'h0000, 1'b0, s, got, exp);
        n_checks++;
        if (s !== 5) begin n_fail++; $display("FAIL evict_stall got %0d expected 5", s); end
        n_checks++;
        if (rd_log[base] !== 16'h0440 || rd_log[base + 3] !== 16'h0443) begin
            n_fail++; $display("FAIL evict_addr got %h..%h expected 0440..0443", rd_log[base], rd_log[base + 3]);
        end
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL evict_data got %h expected %h", got, exp); end
        cpu_op(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, s, got, exp);
        n_checks++;
        if (s !== 5) begin n_fail++; $display("FAIL evicted_line_misses got %0d expected 5", s); end
        n_checks++;
        if (got !== 16'h5501) begin n_fail++; $display("FAIL refetch_data got %h expected 5501", got); end
    endtask

    task automatic test_random();
        int          s;
        int          f0, e0, kind, bad;
        bit          rc, wc, ok;
        logic [15:0] addr, got, exp;
        rand_delay = 1'b1;
        f0 = fills_seen;
        e0 = exp_fills;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            rc   = (kind != 1);
            wc   = (kind == 1 || kind == 2);
            addr = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            cpu_op(rc, wc, addr, 16'($urandom), 1'($urandom_range(0, 1)), s, got, exp);
            n_checks++;
            if (s >= 500) begin n_fail++; $display("FAIL rand_timeout op %0d addr %h", n, addr); end
            else if (rc) begin
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL rand_read op %0d addr %h got %h expected %h", n, addr, got, exp); end
            end
        end
        rand_delay = 1'b0;
        wait_quiet(ok);
        n_checks++;
        if (!ok || (fills_seen - f0) !== (exp_fills - e0)) begin
            n_fail++; $display("FAIL rand_fill_count got %0d expected %0d", fills_seen - f0, exp_fills - e0);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== shadow[a]) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL rand_memory_image got %0d bad words expected 0", bad); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_fills)) begin
            n_fail++; $display("FAIL rand_stats got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_fills);
        end
`endif
    endtask

    task automatic test_reset_mid_fill();
        int          base, w, s;
        address = 16'h1081;
        IO_RC   = 1'b1;
        base    = rd_log.size();
        w       = 0;
        while (rd_log.size() < base + 2 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        RST = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_mem_req got %b expected 0", mem_req); end
        n_checks++;
        if (d_cache_miss !== 1'b1) begin n_fail++; $display("FAIL abort_line_invalid got %b expected 1", d_cache_miss); end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL abort_stats got %h/%h expected 0/0", hit_count, miss_count);
        end
`endif
        @(posedge clk);
        #1;
        RST  = 1'b0;
        base = rd_log.size();
        s    = 0;
        @(negedge clk);
        while (d_cache_miss && s < 500) begin
            s++;
            @(negedge clk);
        end
        n_checks++;
        if (s !== 5) begin n_fail++; $display("FAIL refetch_stall got %0d expected 5", s); end
        n_checks++;
        if (rd_log.size() !== base + 4) begin n_fail++; $display("FAIL refetch_beats got %0d expected 4", rd_log.size() - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_log[base + i] !== 16'h1080 + 16'(i)) begin
                n_fail++; $display("FAIL refetch_addr%0d got %h expected %h", i, rd_log[base + i], 16'h1080 + 16'(i));
            end
        end
        n_checks++;
        if (data_in !== shadow[16'h1081]) begin n_fail++; $display("FAIL refetch_data got %h expected %h", data_in, shadow[16'h1081]); end
        @(posedge clk);
        #1;
        IO_RC = 1'b0;
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        n_checks++;
        if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
            n_fail++; $display("FAIL post_reset_stats got %0d/%0d expected 1/1", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        RST       = 1'b1;
        IO_RC     = 1'b0;
        IO_WC     = 1'b0;
        IO_n_LB_w = 1'b0;
        address   = 16'h0000;
        data_out  = 16'h0000;
        exp_fills = 0;
        exp_hits  = 0;
        for (int a = 0; a < 65536; a++) shadow[a] = init_word(a);
        for (int i = 0; i < 16; i++) begin
            line_valid[i] = 1'b0;
            line_tag[i]   = 10'd0;
        end
        test_reset();
        test_read_miss();
        test_write_through();
        test_back_to_back();
        test_evict();
        test_random();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
